// File: rtl/p23_rx_uart_if.sv
// rtl/p23_rx_uart_if.sv - receive-byte handshake between UART receiver and register block
interface p23_rx_uart_if;
  logic [7:0] rx_data;
  logic       valid;
  logic       ready;

  modport master (output rx_data, output valid, input ready);
  modport slave  (input rx_data, input valid, output ready);
endinterface

// File: rtl/p23_rx_uart.sv
// rtl/p23_rx_uart.sv - 8N1 UART receiver with mid-bit sampling and a small byte FIFO
module p23_rx_uart #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          rx_in,
  input  logic [15:0]   div,
  input  logic          err_clr,
  output logic          framing_error,
  output logic          overrun,
  output logic          busy,
  p23_rx_uart_if.master rxo
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state, state_n;
  logic        rx_m, rx_s, rx_q;
  logic [15:0] cnt, cnt_n, div_r, div_r_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        push, fe_set, sample;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, do_write, ov_set;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      div_r   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_m    <= rx_in;
      rx_s    <= rx_m;
      rx_q    <= rx_s;
      state   <= state_n;
      cnt     <= cnt_n;
      div_r   <= div_r_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  assign sample = (cnt == 16'd0);

  always_comb begin
    state_n   = state;
    cnt_n     = sample ? cnt : cnt - 16'd1;
    div_r_n   = div_r;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push      = 1'b0;
    fe_set    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = cnt;
        if (rx_q && !rx_s) begin
          div_r_n = div;
          cnt_n   = (div >> 1) - 16'd1;
          state_n = START;
        end
      end
      START: if (sample) begin
        if (rx_s) begin
          state_n = IDLE;
        end else begin
          cnt_n     = div_r - 16'd1;
          bit_idx_n = 3'd0;
          state_n   = DATA;
        end
      end
      DATA: if (sample) begin
        shreg_n[bit_idx] = rx_s;
        cnt_n            = div_r - 16'd1;
        bit_idx_n        = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_n = STOP;
      end
      STOP: if (sample) begin
        if (rx_s) begin
          push    = 1'b1;
          state_n = IDLE;
        end else begin
          fe_set  = 1'b1;
          state_n = BREAK;
        end
      end
      BREAK: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Pop is gated by valid, so an empty FIFO ignores a pop that coincides with a push.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = rxo.valid && rxo.ready;
  assign do_write = push && (!full || pop);
  assign ov_set   = push && full && !pop;

  assign rxo.valid   = !empty;
  assign rxo.rx_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_write) begin
        mem[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (fe_set)       framing_error <= 1'b1;
      else if (err_clr) framing_error <= 1'b0;
      if (ov_set)       overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_p23_rx_uart.sv
// tb/tb_p23_rx_uart.sv - directed self-checking bench for p23_rx_uart
module tb_p23_rx_uart;
  logic        clk = 1'b0;
  logic        resetn;
  logic        rx_in;
  logic [15:0] div;
  logic        err_clr;
  logic        framing_error, overrun, busy;
  int          errors = 0;
  int          checks = 0;

  p23_rx_uart_if u_if ();

  p23_rx_uart #(.FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .rx_in         (rx_in),
    .div           (div),
    .err_clr       (err_clr),
    .framing_error (framing_error),
    .overrun       (overrun),
    .busy          (busy),
    .rxo           (u_if)
  );

  always #5 clk = ~clk;

  // Starts just after a rising edge; each bit lasts bl clocks; line is left at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bl);
    @(posedge clk); #1 rx_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (bl) @(posedge clk);
      #1 rx_in = d[i];
    end
    repeat (bl) @(posedge clk);
    #1 rx_in = stop;
    repeat (bl) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    u_if.ready = 1'b1;
    @(posedge clk); #1 u_if.ready = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; rx_in = 1'b1; div = 16'd16; err_clr = 1'b0; u_if.ready = 1'b0;
    #12;
    checks++;
    if ({busy, u_if.valid, framing_error, overrun} !== 4'b0000 || u_if.rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: busy/valid/fe/ov=%b rx_data=%h, want 0000 and 00",
               {busy, u_if.valid, framing_error, overrun}, u_if.rx_data);
    end
    @(posedge clk); #1 resetn = 1'b1;
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_basic();
    fork
      send_frame(8'hA5, 1'b1, 16);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #2 checks++;
        if (u_if.valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early: valid=%b want 0", u_if.valid); end
        @(posedge clk);
        #2 checks++;
        if (u_if.valid !== 1'b1) begin errors++; $display("FAIL basic_valid_rise: valid=%b want 1", u_if.valid); end
      end
    join
    checks++;
    if (u_if.rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", u_if.rx_data); end
    checks++;
    if ({busy, framing_error, overrun} !== 3'b000) begin
      errors++; $display("FAIL basic_flags: busy/fe/ov=%b want 000", {busy, framing_error, overrun});
    end
    pop_one();
    checks++;
    if (u_if.valid !== 1'b0) begin errors++; $display("FAIL basic_pop: valid=%b want 0", u_if.valid); end
  endtask

  task automatic test_glitch();
    @(posedge clk); #1 rx_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_set: busy=%b want 1", busy); end
    @(posedge clk); #1 rx_in = 1'b1;
    repeat (5) @(posedge clk);
    #1 checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hold: busy=%b want 1", busy); end
    @(posedge clk);
    #1 checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_clr: busy=%b want 0", busy); end
    repeat (10) @(posedge clk); #1;
    checks++;
    if ({u_if.valid, framing_error} !== 2'b00) begin
      errors++; $display("FAIL glitch_nopush: valid/fe=%b want 00", {u_if.valid, framing_error});
    end
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, 16);
    checks++;
    if ({framing_error, u_if.valid} !== 2'b10) begin
      errors++; $display("FAIL frame_err: fe/valid=%b want 10", {framing_error, u_if.valid});
    end
    pulse_err_clr();
    repeat (200) @(posedge clk);
    #1 rx_in = 1'b1;
    repeat (20) @(posedge clk); #1;
    checks++;
    if ({framing_error, busy, u_if.valid} !== 3'b000) begin
      errors++; $display("FAIL frame_once: fe/busy/valid=%b want 000", {framing_error, busy, u_if.valid});
    end
    send_frame(8'h11, 1'b1, 16);
    checks++;
    if (u_if.valid !== 1'b1 || u_if.rx_data !== 8'h11) begin
      errors++; $display("FAIL frame_next: valid=%b data=%h want 1 11", u_if.valid, u_if.rx_data);
    end
    pop_one();
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 16);
    checks++;
    if (overrun !== 1'b1 || u_if.valid !== 1'b1) begin
      errors++; $display("FAIL ovr_set: overrun=%b valid=%b want 1 1", overrun, u_if.valid);
    end
    pulse_err_clr();
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: overrun=%b want 0", overrun); end
    for (int i = 1; i <= 4; i++) begin
      exp = 8'(i);
      checks++;
      if (u_if.valid !== 1'b1 || u_if.rx_data !== exp) begin
        errors++; $display("FAIL ovr_pop%0d: valid=%b data=%h want 1 %h", i, u_if.valid, u_if.rx_data, exp);
      end
      pop_one();
    end
    checks++;
    if (u_if.valid !== 1'b0) begin errors++; $display("FAIL ovr_empty: valid=%b want 0", u_if.valid); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_q [5];
    exp_q = '{8'h20, 8'h30, 8'h40, 8'h77, 8'h00};
    send_frame(8'h10, 1'b1, 16);
    send_frame(8'h20, 1'b1, 16);
    send_frame(8'h30, 1'b1, 16);
    send_frame(8'h40, 1'b1, 16);
    fork
      send_frame(8'h77, 1'b1, 16);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1 u_if.ready = 1'b1;
        @(posedge clk); #1 u_if.ready = 1'b0;
      end
    join
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL full_pop_ovr: overrun=%b want 0", overrun); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (u_if.valid !== 1'b1 || u_if.rx_data !== exp_q[i]) begin
        errors++; $display("FAIL full_pop_q%0d: valid=%b data=%h want 1 %h", i, u_if.valid, u_if.rx_data, exp_q[i]);
      end
      pop_one();
    end
    checks++;
    if (u_if.valid !== 1'b0) begin errors++; $display("FAIL full_pop_empty: valid=%b want 0", u_if.valid); end
  endtask

  task automatic test_div10();
    div = 16'd10;
    send_frame(8'h96, 1'b1, 10);
    checks++;
    if (u_if.valid !== 1'b1 || u_if.rx_data !== 8'h96 || framing_error !== 1'b0) begin
      errors++; $display("FAIL div10: valid=%b data=%h fe=%b want 1 96 0", u_if.valid, u_if.rx_data, framing_error);
    end
    pop_one();
    div = 16'd16;
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h5A, 1'b1, 16);
    fork
      send_frame(8'hFF, 1'b1, 16);
      begin
        @(posedge clk);
        repeat (85) @(posedge clk);
        #2 checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: busy=%b want 1", busy); end
        resetn = 1'b0;
        #1 checks++;
        if ({busy, u_if.valid, framing_error, overrun} !== 4'b0000 || u_if.rx_data !== 8'h00) begin
          errors++;
          $display("FAIL rst_mid_state: busy/valid/fe/ov=%b data=%h want 0000 00",
                   {busy, u_if.valid, framing_error, overrun}, u_if.rx_data);
        end
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
      end
    join
    checks++;
    if (u_if.valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_lost: valid=%b busy=%b want 0 0", u_if.valid, busy);
    end
    send_frame(8'h42, 1'b1, 16);
    checks++;
    if (u_if.valid !== 1'b1 || u_if.rx_data !== 8'h42) begin
      errors++; $display("FAIL rst_mid_next: valid=%b data=%h want 1 42", u_if.valid, u_if.rx_data);
    end
    pop_one();
    checks++;
    if (u_if.valid !== 1'b0) begin errors++; $display("FAIL rst_mid_only: valid=%b want 0", u_if.valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_full_pop();
    test_div10();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/p23_rx_uart.md
Name: p23_rx_uart

Overview:
- 8N1 UART receiver, counterpart to the SoC's TX UART; shares its `div` baud setting (SYSTEM_CYCLES/BAUDRATE).
- Synchronizes the asynchronous rx line and validates the start bit at mid-bit.
- Samples 8 data bits LSB-first, checks the stop bit, and queues good bytes in a small FIFO.
- The CPU-side UART register block drains the FIFO through a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4, number of received bytes buffered; power of two, 2..16.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; one clock; reset is asynchronous and active-low.
- rx_in  in  1  serial line, asynchronous, idle high.
- div  in  16  clocks per bit; valid range >= 4; captured at start-bit detect.
- rx_data  out  8  FIFO head byte; held stable while valid=1 and no pop occurs.
- valid  out  1  FIFO non-empty.
- ready  in  1  consumer pop; a pop occurs on a clk edge with valid&ready.
- err_clr  in  1  clears framing_error and overrun (single-cycle pulse).
- framing_error  out  1  sticky; a stop bit was sampled low.
- overrun  out  1  sticky; a byte was dropped because the FIFO was full.
- busy  out  1  receive FSM not in IDLE.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - Synchronizer flops = 1; FSM = IDLE; FIFO empty.
  - valid=0, busy=0, framing_error=0, overrun=0, rx_data=0.
- Synchronizer: two flops, giving rx_s. Edge detect compares rx_s with its one-cycle-delayed copy rx_q.
- Counter: one 16-bit down-counter, cnt, serves all waits. A sample happens on the cycle cnt==0.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - Falling edge (rx_q=1, rx_s=0) latches div_r=div, loads cnt=(div>>1)-1, goes to START.
- START:
  - At the sample, rx_s=1 is a glitch: go to IDLE, nothing pushed, no error.
  - Otherwise: cnt=div_r-1, bit_idx=0, go to DATA.
- DATA:
  - Each sample shifts rx_s into shreg[bit_idx] (LSB first), reloads cnt=div_r-1, increments bit_idx.
  - After the sample with bit_idx==7, go to STOP.
- STOP:
  - Sample rx_s=1: push shreg, go to IDLE.
  - Sample rx_s=0: set framing_error, discard byte, go to BREAK.
- BREAK: stay until rx_s==1, then go to IDLE. A held-low line yields exactly one framing error.
- Timing (T = cycle the falling edge is seen on rx_s):
  - Start sample at T+(div>>1).
  - Data bit k sample at T+(div>>1)+(k+1)*div.
  - Stop sample at T+(div>>1)+9*div.
  - Byte written to FIFO at the edge ending the stop-sample cycle.
  - valid=1 from the next cycle.
- FIFO:
  - Registered wr/rd pointers with one extra wrap bit; depth FIFO_DEPTH.
  - rx_data = mem[rd_ptr].
  - Pop with valid=0 is ignored.
- Full FIFO:
  - Push with no pop: byte dropped, overrun=1.
  - Push with a simultaneous pop: both happen, no overrun.
- Empty FIFO with simultaneous push and pop: the pop is ignored, push accepted.
- Flag priority: if err_clr coincides with a new error event in the same cycle, the set wins.
- div changes mid-frame have no effect until the next start bit.
- div<4 is unsupported; behaviour is undefined but the FSM must not lock up.
- Reset asserted mid-frame: immediate return to IDLE, partial byte lost, FIFO cleared.
- busy=1 in START, DATA, STOP and BREAK.

Test Plan:
- Basic receive: div=16, drive 0xA5 framed 8N1 at 16 clk/bit, ready=0 -> valid rises one cycle after the stop sample; rx_data=0xA5; both flags 0; busy=0 afterwards.
- Glitch rejection: div=16, rx_in low for 5 clk then high -> busy goes 1 then 0 after the start sample; no push; framing_error=0.
- Framing error: div=16, 0x3C with stop bit low, rx_in then held low 200 clk, then high, then valid 0x11 -> framing_error=1 exactly once; 0x3C not queued; 0x11 queued.
- Overrun: FIFO_DEPTH=4, ready=0, send 0x01..0x05 -> FIFO holds 0x01..0x04; overrun=1. Pulse err_clr -> overrun=0. Pop 4 -> 0x01,0x02,0x03,0x04 in order, then valid=0.
- Full plus simultaneous pop: FIFO full, ready held 1 on the push cycle of 0x77 -> overrun stays 0; 0x77 emerges last.
- Reset mid-frame: assert resetn=0 during bit 4 of 0xFF, release, send 0x42 -> only 0x42 received; all outputs at reset values while resetn=0.
